// File: rtl/score_seg7_display.sv
// score_seg7_display: 4-digit BCD score register with saturation, scanned onto
// the Basys 3 seven-segment display. The scan is paced by the external TICK strobe.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module score_seg7_display #(
    parameter int          SCORE_STEP = 1,
    parameter logic [15:0] MAX_SCORE  = 16'h9999
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        TICK,
    input  logic        SCORE_INC,
    input  logic        SCORE_CLR,
    output logic [3:0]  SEG_SELECT,
    output logic [7:0]  HEX_OUT,
    output logic [15:0] SCORE,
    output logic        MAX_FLAG
);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    localparam logic [4:0] STEP5 = 5'(SCORE_STEP);

    state_t      r_state;
    state_t      w_state_nx;
    logic [1:0]  r_digit;
    logic [1:0]  w_digit_nx;
    logic        r_armed;
    logic        w_armed_nx;
    logic [15:0] r_score;
    logic [15:0] w_score_nx;
    logic        r_max_flag;
    logic [3:0]  r_seg;
    logic [3:0]  w_seg_nx;
    logic [7:0]  r_hex;
    logic [7:0]  w_hex_nx;

    // Per-nibble decimal add of SCORE_STEP; a carry out of the top digit or a
    // result above the ceiling clamps to MAX_SCORE so the score never wraps.
    function automatic logic [15:0] bcd_add_sat(input logic [15:0] a);
        logic [15:0] s;
        logic [4:0]  n;
        logic        c;
        s = 16'h0000;
        c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n = {1'b0, a[4*i +: 4]} + ((i == 0) ? STEP5 : 5'd0) + {4'b0000, c};
            if (n > 5'd9) begin
                n = n - 5'd10;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            s[4*i +: 4] = n[3:0];
        end
        if (c || (s > MAX_SCORE)) begin
            return MAX_SCORE;
        end
        return s;
    endfunction

    // Active-low segment pattern, dp off; non-decimal nibbles stay dark.
    function automatic logic [7:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Segment pattern for digit d of score s, with optional leading-zero blanking.
    function automatic logic [7:0] digit_hex(input logic [15:0] s, input logic [1:0] d);
        logic [3:0] nib;
        logic       lead_zero;
        case (d)
            2'd0:    begin nib = s[3:0];   lead_zero = 1'b0;            end
            2'd1:    begin nib = s[7:4];   lead_zero = (s[15:4] == 12'h000); end
            2'd2:    begin nib = s[11:8];  lead_zero = (s[15:8] == 8'h00);   end
            default: begin nib = s[15:12]; lead_zero = (s[15:12] == 4'h0);   end
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if (lead_zero) begin
            return 8'hFF;
        end
`else
        if (lead_zero && 1'b0) begin
            return 8'hFF;
        end
`endif
        return seg_decode(nib);
    endfunction

    // Next score: clear wins over increment; increment saturates at the ceiling.
    always_comb begin
        w_score_nx = r_score;
        if (SCORE_CLR) begin
            w_score_nx = 16'h0000;
        end else if (SCORE_INC) begin
            w_score_nx = bcd_add_sat(r_score);
        end
    end

    // Score and ceiling flag registers; the flag tracks the value being loaded.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_score    <= 16'h0000;
            r_max_flag <= 1'b0;
        end else begin
            r_score    <= w_score_nx;
            r_max_flag <= (w_score_nx == MAX_SCORE);
        end
    end

    // Scan next-state and next outputs; outputs are derived from the next state
    // so the registered outputs line up with the state register.
    always_comb begin
        w_state_nx = r_state;
        w_digit_nx = r_digit;
        w_armed_nx = r_armed;
        w_seg_nx   = 4'b1111;
        w_hex_nx   = 8'hFF;
        case (r_state)
            ST_BLANK: begin
                // Out of reset the display stays dark until the first TICK.
                if (r_armed || TICK) begin
                    w_state_nx = ST_SHOW;
                    w_armed_nx = 1'b1;
                end
            end
            default: begin
                if (TICK) begin
                    w_state_nx = ST_BLANK;
                    w_digit_nx = r_digit + 2'd1;
                end
            end
        endcase
        if (w_state_nx == ST_SHOW) begin
            w_seg_nx = ~(4'b0001 << w_digit_nx);
            w_hex_nx = digit_hex(r_score, w_digit_nx);
        end
    end

    // Scan state, digit index and registered display outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_BLANK;
            r_digit <= 2'd0;
            r_armed <= 1'b0;
            r_seg   <= 4'b1111;
            r_hex   <= 8'hFF;
        end else begin
            r_state <= w_state_nx;
            r_digit <= w_digit_nx;
            r_armed <= w_armed_nx;
            r_seg   <= w_seg_nx;
            r_hex   <= w_hex_nx;
        end
    end

    assign SEG_SELECT = r_seg;
    assign HEX_OUT    = r_hex;
    assign SCORE      = r_score;
    assign MAX_FLAG   = r_max_flag;

endmodule

// File: tb/tb_score_seg7_display.sv
// Directed bench for score_seg7_display with hand-computed expectations.
module tb_score_seg7_display;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        TICK = 1'b0;
    logic        SCORE_INC = 1'b0;
    logic        SCORE_CLR = 1'b0;
    logic [3:0]  SEG_SELECT;
    logic [7:0]  HEX_OUT;
    logic [15:0] SCORE;
    logic        MAX_FLAG;

    int checks = 0;
    int failures = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] LZ_HEX = 8'hFF;
`else
    localparam logic [7:0] LZ_HEX = 8'hC0;
`endif

    score_seg7_display #(.SCORE_STEP(1), .MAX_SCORE(16'h9999)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .TICK(TICK),
        .SCORE_INC(SCORE_INC),
        .SCORE_CLR(SCORE_CLR),
        .SEG_SELECT(SEG_SELECT),
        .HEX_OUT(HEX_OUT),
        .SCORE(SCORE),
        .MAX_FLAG(MAX_FLAG)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle 1 ns past it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_tick();
        TICK = 1'b1;
        step();
        TICK = 1'b0;
    endtask

    task automatic pulse_inc();
        SCORE_INC = 1'b1;
        step();
        SCORE_INC = 1'b0;
    endtask

    task automatic pulse_clr();
        SCORE_CLR = 1'b1;
        step();
        SCORE_CLR = 1'b0;
    endtask

    task automatic hold_inc(input int n);
        SCORE_INC = 1'b1;
        repeat (n) step();
        SCORE_INC = 1'b0;
    endtask

    initial begin
        #1;
        // 1: reset and scan start
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("rst_seg", SEG_SELECT, 4'b1111);
        check("rst_hex", HEX_OUT, 8'hFF);
        check("rst_score", SCORE, 16'h0000);
        check("rst_max", MAX_FLAG, 1'b0);
        repeat (5) step();
        check("idle_seg", SEG_SELECT, 4'b1111);
        pulse_tick();
        check("t1_seg", SEG_SELECT, 4'b1110);
        check("t1_hex", HEX_OUT, 8'hC0);
        repeat (9) step();
        pulse_tick();
        check("t2_blank_seg", SEG_SELECT, 4'b1111);
        check("t2_blank_hex", HEX_OUT, 8'hFF);
        step();
        check("t2_seg", SEG_SELECT, 4'b1101);
        check("t2_hex", HEX_OUT, 8'hC0);
        repeat (8) step();
        pulse_tick();
        check("t3_blank_seg", SEG_SELECT, 4'b1111);
        step();
        check("t3_seg", SEG_SELECT, 4'b1011);
        check("t3_hex", HEX_OUT, 8'hC0);

        // 2: 123 increments, digit 2 currently active
        repeat (123) pulse_inc();
        check("s123", SCORE, 16'h0123);
        step();
        check("d2_hex", HEX_OUT, 8'hF9);
        pulse_tick();
        step();
        check("d3_seg", SEG_SELECT, 4'b0111);
        check("d3_hex", HEX_OUT, LZ_HEX);
        pulse_tick();
        step();
        check("d0_seg", SEG_SELECT, 4'b1110);
        check("d0_hex", HEX_OUT, 8'hB0);
        pulse_tick();
        step();
        check("d1_hex", HEX_OUT, 8'hA4);

        // decimal carry 0099 -> 0100
        pulse_clr();
        check("clr", SCORE, 16'h0000);
        hold_inc(99);
        check("s99", SCORE, 16'h0099);
        pulse_inc();
        check("carry", SCORE, 16'h0100);

        // 3: saturation
        pulse_clr();
        hold_inc(9998);
        check("s9998", SCORE, 16'h9998);
        check("s9998_max", MAX_FLAG, 1'b0);
        pulse_inc();
        check("sat1", SCORE, 16'h9999);
        check("sat1_max", MAX_FLAG, 1'b1);
        pulse_inc();
        check("sat2", SCORE, 16'h9999);
        pulse_inc();
        check("sat3", SCORE, 16'h9999);
        check("sat3_max", MAX_FLAG, 1'b1);

        // 4: clear beats increment
        pulse_clr();
        check("clr_max", MAX_FLAG, 1'b0);
        hold_inc(50);
        check("s50", SCORE, 16'h0050);
        SCORE_INC = 1'b1;
        SCORE_CLR = 1'b1;
        step();
        SCORE_INC = 1'b0;
        SCORE_CLR = 1'b0;
        check("incclr", SCORE, 16'h0000);
        check("incclr_max", MAX_FLAG, 1'b0);

        // 5: reset while showing digit 2
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        pulse_tick();
        pulse_tick();
        step();
        pulse_tick();
        step();
        check("pre_rst_seg", SEG_SELECT, 4'b1011);
        hold_inc(7);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("mid_rst_seg", SEG_SELECT, 4'b1111);
        check("mid_rst_hex", HEX_OUT, 8'hFF);
        check("mid_rst_score", SCORE, 16'h0000);
        repeat (3) step();
        check("mid_rst_idle", SEG_SELECT, 4'b1111);
        pulse_tick();
        check("post_rst_seg", SEG_SELECT, 4'b1110);

        // 6: leading zero display of 0042, digit 0 active
        hold_inc(42);
        check("s42", SCORE, 16'h0042);
        step();
        check("z0_hex", HEX_OUT, 8'hA4);
        pulse_tick();
        step();
        check("z1_hex", HEX_OUT, 8'h99);
        pulse_tick();
        step();
        check("z2_seg", SEG_SELECT, 4'b1011);
        check("z2_hex", HEX_OUT, LZ_HEX);
        pulse_tick();
        step();
        check("z3_hex", HEX_OUT, LZ_HEX);

        // continuous TICK advances once per two cycles: 3 -> 0 -> 1
        TICK = 1'b1;
        step();
        check("ct_blank", SEG_SELECT, 4'b1111);
        step();
        check("ct_d0", SEG_SELECT, 4'b1110);
        step();
        check("ct_blank2", SEG_SELECT, 4'b1111);
        step();
        check("ct_d1", SEG_SELECT, 4'b1101);
        TICK = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
